// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage buffer: valid/ready payload register with optional skid entry,
// AND-of-go stall control, synchronous flush and a saturating flushed-beat counter.
module pipe_stage_buf #(
  parameter int                DATA_W    = 57,
  parameter int                GO_N      = 2,
  parameter int                SKID      = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter int                CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic [GO_N-1:0]   go,
  input  logic              clear,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam bit HAS_SKID = (SKID != 0);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;

  logic              go_all;
  logic              in_fire;
  logic              out_fire;
  logic [1:0]        held;
  logic [CNT_W:0]    cnt_sum;
  logic [CNT_W-1:0]  cnt_next;

  assign go_all = &go;

  // With a skid entry, in_ready only looks at local state so out_ready never reaches it.
  always_comb begin
    if (HAS_SKID) begin
      in_ready = go_all & ~s_valid & ~clear;
    end else begin
      in_ready = go_all & ~clear & (~m_valid | out_ready);
    end
  end

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_valid & out_ready & go_all & ~clear;

  assign held      = {1'b0, m_valid} + {1'b0, s_valid};
  assign occupancy = held;
  assign out_valid = m_valid;
  assign out_data  = m_valid ? m_data : CLEAR_VAL;

  assign cnt_sum  = {1'b0, flush_cnt} + {{(CNT_W-1){1'b0}}, held};
  assign cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_data    <= CLEAR_VAL;
      s_valid   <= 1'b0;
      s_data    <= CLEAR_VAL;
      flush_cnt <= '0;
    end else if (clear) begin
      m_valid   <= 1'b0;
      m_data    <= CLEAR_VAL;
      s_valid   <= 1'b0;
      s_data    <= CLEAR_VAL;
      flush_cnt <= cnt_next;
    end else if (go_all) begin
      if (!m_valid || out_fire) begin
        if (s_valid) begin
          m_valid <= 1'b1;
          m_data  <= s_data;
          if (in_fire) begin
            s_data <= in_data;
          end else begin
            s_valid <= 1'b0;
            s_data  <= CLEAR_VAL;
          end
        end else if (in_fire) begin
          m_valid <= 1'b1;
          m_data  <= in_data;
        end else begin
          m_valid <= 1'b0;
          m_data  <= CLEAR_VAL;
        end
      end else if (in_fire && HAS_SKID) begin
        // Main entry is stuck downstream; park the new beat in the skid entry.
        s_valid <= 1'b1;
        s_data  <= in_data;
      end
    end
  end

endmodule
